fm_tx_modulator: RTL



---
 rtl/fm_tx_modulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fm_tx_modulator.sv
// fm_tx_modulator: continuous-phase FM modulator.
// Each 16-bit audio sample is held for INTERP output beats. It sets the phase
// increment of a free-running accumulator, and every beat emits the
// cos/sin of the accumulated phase as a packed {Q, I} word.
module fm_tx_modulator #(
    parameter int INTERP      = 8,
    parameter int PHASE_W     = 24,
    parameter int DEV_SHIFT   = 8,
    parameter int CARRIER_INC = 0
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic [15:0] audio_in_V_TDATA,
    input  logic        audio_in_V_TVALID,
    output logic        audio_in_V_TREADY,
    output logic [31:0] iq_out_V_TDATA,
    output logic        iq_out_V_TVALID,
    input  logic        iq_out_V_TREADY
);

    localparam int               CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERP - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    // Quarter-wave sample, rounded to nearest; only evaluated at elaboration.
    function automatic int quarter_sin(input int n);
        real v;
        v = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(n) / 1024.0);
        return $rtoi(v + 0.5);
    endfunction

    // Audio sample to phase increment: sign-extend, scale by the deviation shift,
    // add the carrier. The result wraps modulo 2^PHASE_W.
    function automatic logic [PHASE_W-1:0] audio_to_inc(input logic [15:0] s);
        logic signed [PHASE_W-1:0] ext;
        ext = PHASE_W'(signed'(s));
        return PHASE_W'(CARRIER_INC) + (ext <<< DEV_SHIFT);
    endfunction

    // Quadrant folding of the quarter table. The magnitude is at most 32767,
    // so negation never reaches -32768.
    function automatic logic signed [15:0] quad_sin(input logic [1:0]  quad,
                                                    input logic [15:0] q_fwd,
                                                    input logic [15:0] q_rev);
        logic signed [15:0] mag;
        mag = quad[0] ? signed'(q_rev) : signed'(q_fwd);
        return quad[1] ? -mag : mag;
    endfunction

    logic [15:0] qtab [0:256];
    for (genvar g = 0; g <= 256; g++) begin : g_qtab
        assign qtab[g] = 16'(quarter_sin(g));
    end

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [PHASE_W-1:0]  phase, phase_nx;
    logic [PHASE_W-1:0]  inc, inc_nx;
    logic [31:0]         data_p1, data_nx;
    logic                vld_p1, vld_nx;
    logic                load_en;
    logic                ready_c;

    logic [9:0]          addr_s, addr_c;
    logic signed [15:0]  sin_p0, cos_p0;

    // Stage p0: table lookup from the current phase (cos is sin advanced a quarter turn)
    assign addr_s = phase[PHASE_W-1 -: 10];
    assign addr_c = addr_s + 10'd256;
    assign sin_p0 = quad_sin(addr_s[9:8], qtab[{1'b0, addr_s[7:0]}],
                             qtab[9'd256 - {1'b0, addr_s[7:0]}]);
    assign cos_p0 = quad_sin(addr_c[9:8], qtab[{1'b0, addr_c[7:0]}],
                             qtab[9'd256 - {1'b0, addr_c[7:0]}]);

    assign load_en = !vld_p1 || iq_out_V_TREADY;

    // Next-state, accumulator and output-register load decisions
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        phase_nx = phase;
        inc_nx   = inc;
        data_nx  = data_p1;
        vld_nx   = vld_p1;
        ready_c  = 1'b0;
        case (state)
            IDLE: begin
                ready_c = 1'b1;
                if (iq_out_V_TREADY) begin
                    vld_nx = 1'b0;
                end
                if (audio_in_V_TVALID) begin
                    inc_nx   = audio_to_inc(audio_in_V_TDATA);
                    cnt_nx   = '0;
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (load_en) begin
                    data_nx  = {sin_p0, cos_p0};
                    vld_nx   = 1'b1;
                    phase_nx = phase + inc;
                    if (cnt == CNT_LAST) begin
                        // Last beat of this sample: accept the next one in the same cycle
                        ready_c = 1'b1;
                        cnt_nx  = '0;
                        if (audio_in_V_TVALID) begin
                            inc_nx = audio_to_inc(audio_in_V_TDATA);
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p1: registered state, accumulator and output word
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            phase   <= '0;
            inc     <= '0;
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            phase   <= phase_nx;
            inc     <= inc_nx;
            data_p1 <= data_nx;
            vld_p1  <= vld_nx;
        end
    end

    assign audio_in_V_TREADY = ready_c && ap_rst_n;
    assign iq_out_V_TDATA    = data_p1;
    assign iq_out_V_TVALID   = vld_p1;

endmodule
